sm_sync_fifo_ext: RTL and testbench
===================================

# sm_sync_fifo_ext

Parametrised single-clock FIFO, the next generation of our synchronous FIFO, sitting between a producer and consumer in the same clock domain. It adds arbitrary (non-power-of-two) depth, programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow pulses, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.

## Interface
- DW, 8, data width in bits (≥1)
- FIFO_DEPTH, 5, number of entries (≥2, any integer)
- AF_LEVEL, FIFO_DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (1..FIFO_DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL (0..FIFO_DEPTH-1)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- CW, $clog2(FIFO_DEPTH+1), derived count width; not overridden

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of contents
- wr_en  in  1  push request
- rd_en  in  1  pop request
- data_in  in  DW  push data
- data_out  out  DW  read data
- empty  out  1  count == 0
- full  out  1  count == FIFO_DEPTH
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  CW  current occupancy
- overflow  out  1  one-cycle pulse: push dropped
- underflow  out  1  one-cycle pulse: pop refused

## Operation
- Storage: FIFO_DEPTH×DW array, not reset. Write pointer wp and read pointer rp in 0..FIFO_DEPTH-1; each wraps FIFO_DEPTH-1 → 0 explicitly (no power-of-two modulo).
- Accepted read: rd_acc = rd_en & ~empty.
- Accepted write: wr_acc = wr_en & (~full | rd_acc). Push on a full FIFO with a simultaneous accepted pop is legal: head leaves, tail enters, count unchanged.
- Push+pop on an empty FIFO: write accepted, read refused (underflow pulse), count → 1.
- count next = count + wr_acc − rd_acc; never exceeds FIFO_DEPTH or goes below 0.
- Flags are decoded combinationally from the registered count only; no combinational path from wr_en/rd_en to any flag.
- overflow: registered; high the cycle after an edge where wr_en & ~wr_acc; data_in discarded, state unchanged.
- underflow: registered; high the cycle after an edge where rd_en & empty.
- FWFT=0: data_out is a register loaded with mem[rp] on the rd_acc edge; holds its value otherwise.
- FWFT=1: data_out = mem[rp] whenever ~empty; rd_en acts as acknowledge and advances rp. data_out is don't-care while empty (bench must not check).
- Priority: rst > flush > wr/rd. Flush: wp, rp, count ← 0; overflow/underflow ← 0; data_out ← 0 in FWFT=0 mode; wr_en/rd_en in that cycle are ignored with no error pulses.
- Reset: wp=rp=count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=underflow=0, data_out=0.

## Timing
- Write latency: data pushed on edge N is poppable from edge N+1 (empty falls after edge N).
- FWFT=0 read latency: data appears on data_out after the rd_acc edge (1 cycle).
- FWFT=1 read latency: head valid in the same cycle empty is low; 0 cycles from rd_en.
- Flags and count update after the same edge as the causing push/pop.
- Error pulses last exactly one cycle per offending edge; back-to-back offenders give continuous high.
- Reset or flush asserted mid-burst takes effect at that edge; the next edge behaves as from reset.

## Test plan
- Reset, then 5 pushes 0x11..0x15 (DEPTH=5, AF_LEVEL=4): count 1..5, almost_full high at count 4, full at 5; 6th push 0xFF → overflow pulse, count stays 5, later pops return 0x11..0x15 in order.
- Full FIFO, push 0xA0 + pop same cycle: count stays 5, full stays high, no overflow; drained order 0x12..0x15, 0xA0.
- Empty FIFO, rd_en alone → underflow one cycle, count 0; rd_en+wr_en 0x5A → underflow, count 1, next pop returns 0x5A.
- Wrap: 1000 cycles random push/pop (60%/50%), scoreboard against queue model; pointers cross index 4→0 many times, zero mismatches, no flag/count disagreement.
- FWFT=1: push 0x3C on empty → next cycle empty=0, data_out=0x3C without rd_en; rd_en → empty next cycle.
- Flush with count=3 and wr_en high: next cycle count 0, empty 1, no overflow/underflow; rst mid-burst: all outputs at reset values next cycle.

Source files
------------

// File: rtl/sm_sync_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module      : sm_sync_fifo_ext
// Description : Single-clock FIFO with arbitrary (non-power-of-two) depth,
//               programmable almost-full / almost-empty thresholds, an
//               occupancy count, registered overflow/underflow pulses, a
//               synchronous flush and a selectable first-word-fall-through
//               read mode.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DW          data width in bits
//   FIFO_DEPTH  number of entries (any integer >= 2)
//   AF_LEVEL    almost_full  asserts when count >= AF_LEVEL
//   AE_LEVEL    almost_empty asserts when count <= AE_LEVEL
//   FWFT        0 = registered read data, 1 = first-word-fall-through
//   CW          derived count width, leave at its default
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   flush         synchronous clear of contents (lower priority than rst)
//   wr_en         push request, data_in captured when accepted
//   rd_en         pop request (acknowledge of the head in FWFT mode)
//   data_in       push data
//   data_out      read data
//   empty / full  count == 0 / count == FIFO_DEPTH
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         current occupancy
//   overflow      one-cycle pulse after a dropped push
//   underflow     one-cycle pulse after a refused pop
// ============================================================================
module sm_sync_fifo_ext #(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 5,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  // Pointer width is sized to address exactly FIFO_DEPTH entries.
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [PW-1:0] c_last_idx = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] c_depth    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] c_af_level = CW'(AF_LEVEL);
  localparam logic [CW-1:0] c_ae_level = CW'(AE_LEVEL);

  // Storage is intentionally not reset; occupancy tracking makes stale
  // contents unobservable.
  logic [DW-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_empty;
  logic          w_full;
  logic          w_rd_acc;
  logic          w_wr_acc;

  // Pointers wrap explicitly so any depth works, not only powers of two.
  function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] ptr);
    return (ptr == c_last_idx) ? '0 : ptr + PW'(1);
  endfunction

  // Status is derived only from the registered count, so no flag has a
  // combinational path from wr_en/rd_en.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);

  // A pop is honoured only when data is present. A push on a full FIFO is
  // still legal when a pop frees the head slot in the same cycle.
  assign w_rd_acc = rd_en & ~w_empty;
  assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

  // --------------------------------------------------------------------------
  // Pointer, occupancy and error-pulse registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      // Requests coinciding with a flush are discarded without error pulses.
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wp <= f_next_ptr(r_wp);
      end
      if (w_rd_acc) begin
        r_rp <= f_next_ptr(r_rp);
      end
      // Simultaneous accepted push and pop leave the count unchanged.
      if (w_wr_acc && !w_rd_acc) begin
        r_count <= r_count + CW'(1);
      end else if (!w_wr_acc && w_rd_acc) begin
        r_count <= r_count - CW'(1);
      end
      r_overflow  <= wr_en & ~w_wr_acc;
      r_underflow <= rd_en & w_empty;
    end
  end

  // --------------------------------------------------------------------------
  // Storage write port. When full with a concurrent pop, wp == rp, so the
  // incoming word lands in the slot the head is leaving; the read side sees
  // the old contents because the update is non-blocking.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_wr_acc) begin
      mem[r_wp] <= data_in;
    end
  end

  // --------------------------------------------------------------------------
  // Read data path
  // --------------------------------------------------------------------------
  generate
    if (FWFT != 0) begin : g_fwft
      // Head is presented directly; rd_en only acknowledges it. The value is
      // meaningless while empty.
      assign data_out = mem[r_rp];
    end else begin : g_std
      logic [DW-1:0] r_data_out;

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          r_data_out <= '0;
        end else if (w_rd_acc) begin
          r_data_out <= mem[r_rp];
        end
      end

      assign data_out = r_data_out;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (r_count >= c_af_level);
  assign almost_empty = (r_count <= c_ae_level);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sm_sync_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm_sync_fifo_ext
// Description : Self-checking bench for sm_sync_fifo_ext. Two instances, one
//               per read mode, share the same stimulus. A queue-based model
//               predicts occupancy, error pulses and pop data; a monitor
//               compares DUT outputs against the scoreboard queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_sync_fifo_ext;

  localparam int D  = 5;
  localparam int AF = 4;
  localparam int AE = 1;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [7:0]    data_in = 8'h00;

  logic [7:0]    dout0, dout1;
  logic          empty0, full0, af0, ae0, ovf0, unf0;
  logic          empty1, full1, af1, ae1, ovf1, unf1;
  logic [CW-1:0] cnt0, cnt1;

  sm_sync_fifo_ext #(
    .DW(8), .FIFO_DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)
  ) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(dout0), .empty(empty0), .full(full0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .overflow(ovf0), .underflow(unf0)
  );

  sm_sync_fifo_ext #(
    .DW(8), .FIFO_DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)
  ) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(dout1), .empty(empty1), .full(full1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .overflow(ovf1), .underflow(unf1)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  typedef struct {
    int cnt;
    bit ovf;
    bit unf;
    bit chk_d;   // data_out of the registered-read instance must be zero
  } st_t;

  logic [7:0] mq[$];    // reference FIFO contents
  logic [7:0] dq0[$];   // expected pop data, registered-read instance
  logic [7:0] dq1[$];   // expected pop data, fall-through instance
  st_t        sq[$];    // expected post-edge status

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_status(input string tag, input st_t st, input logic [CW-1:0] c,
                            input logic e, input logic f, input logic af,
                            input logic ae, input logic ov, input logic un);
    check({tag, "_count"}, 32'(c), 32'(st.cnt));
    check({tag, "_empty"}, 32'(e), 32'(st.cnt == 0));
    check({tag, "_full"}, 32'(f), 32'(st.cnt == D));
    check({tag, "_almost_full"}, 32'(af), 32'(st.cnt >= AF));
    check({tag, "_almost_empty"}, 32'(ae), 32'(st.cnt <= AE));
    check({tag, "_overflow"}, 32'(ov), 32'(st.ovf));
    check({tag, "_underflow"}, 32'(un), 32'(st.unf));
  endtask

  // --------------------------------------------------------------------------
  // One clock of stimulus. Called at posedge+1; returns at the next posedge+1.
  // --------------------------------------------------------------------------
  task automatic step(input bit w, input bit r, input logic [7:0] d,
                      input bit f = 1'b0, input bit s = 1'b0);
    st_t        st;
    bit         ra;
    bit         wa;
    bit         popped;
    logic [7:0] head;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    flush   = f;
    rst     = s;
    st.ovf   = 1'b0;
    st.unf   = 1'b0;
    st.chk_d = 1'b0;
    popped   = 1'b0;
    head     = 8'h00;
    if (s || f) begin
      mq.delete();
      st.chk_d = 1'b1;
    end else begin
      ra     = r && (mq.size() > 0);
      wa     = w && ((mq.size() < D) || ra);
      st.unf = r && (mq.size() == 0);
      st.ovf = w && !wa;
      if (ra) begin
        head   = mq.pop_front();
        popped = 1'b1;
        dq1.push_back(head);   // fall-through: head visible before the edge
      end
      if (wa) mq.push_back(d);
    end
    st.cnt = mq.size();
    @(posedge clk);
    if (popped) dq0.push_back(head);  // registered: visible after the edge
    sq.push_back(st);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Monitor: samples on the falling edge, away from the active edge.
  // --------------------------------------------------------------------------
  bit pend0 = 1'b0;

  always @(negedge clk) begin
    st_t st;
    if (pend0) begin
      if (dq0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rdata_std: got 0x%0h expected no read at %0t", dout0, $time);
      end else begin
        check("rdata_std", 32'(dout0), 32'(dq0.pop_front()));
      end
    end
    pend0 = rd_en && !empty0 && !rst && !flush;

    if (rd_en && !empty1 && !rst && !flush) begin
      if (dq1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rdata_fwft: got 0x%0h expected no read at %0t", dout1, $time);
      end else begin
        check("rdata_fwft", 32'(dout1), 32'(dq1.pop_front()));
      end
    end

    if (sq.size() > 0) begin
      st = sq.pop_front();
      chk_status("std", st, cnt0, empty0, full0, af0, ae0, ovf0, unf0);
      chk_status("fwft", st, cnt1, empty1, full1, af1, ae1, ovf1, unf1);
      if (st.chk_d) check("std_dout_cleared", 32'(dout0), 32'h0);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    @(posedge clk);
    #1;
    repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Fill to full, then one dropped push.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h11 + i));
    step(1'b1, 1'b0, 8'hFF);
    // Push and pop together while full.
    step(1'b1, 1'b1, 8'hA0);
    // Drain: 0x12..0x15 then 0xA0.
    repeat (5) step(1'b0, 1'b1, 8'h00);

    // Underflow alone, then push+pop on empty, then pop the pushed word.
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h5A);
    step(1'b0, 1'b1, 8'h00);

    // Fall-through head visible without rd_en.
    step(1'b1, 1'b0, 8'h3C);
    check("fwft_head_no_rd", 32'(dout1), 32'h3C);
    check("fwft_not_empty", 32'(empty1), 32'h0);
    step(1'b0, 1'b0, 8'h00);
    check("fwft_head_held", 32'(dout1), 32'h3C);
    step(1'b0, 1'b1, 8'h00);

    // Random traffic, pointers wrap many times.
    for (int i = 0; i < 1000; i++) begin
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
           8'($urandom_range(0, 255)));
    end

    // Flush with three entries and a concurrent push.
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    step(1'b1, 1'b0, 8'h77, 1'b1);
    step(1'b0, 1'b1, 8'h00);

    // Reset in the middle of a burst.
    for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    step(1'b1, 1'b1, 8'h99, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h42);
    step(1'b0, 1'b1, 8'h00);

    repeat (3) step(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(dq0.size() + dq1.size() + sq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
